frame_scan_11011: RTL and testbench

- Frame-level sequencer for the 11011 Moore pattern detector.
- Accepts a W-bit frame over a valid/ready handshake and serializes it MSB-first, one bit per clock, into an embedded overlapping 11011 Moore FSM.
- Counts detections and records the bit position of the first match.
- Returns the result over a second valid/ready handshake; sits between a frame producer and a result consumer so software-style traffic can drive the bit-serial detector.

---
 rtl/frame_scan_11011_if.sv | 27 ++
 rtl/frame_scan_11011.sv | 143 ++++++++++++++
 tb/tb_frame_scan_11011.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_scan_11011_if.sv
// Frame-in / result-out handshake bundle for frame_scan_11011.
// The master side drives frames and takes results; the slave side is the scanner.
interface frame_scan_11011_if #(
   parameter int W = 16
) ();
   localparam int CW = $clog2(W + 1);
   localparam int PW = $clog2(W);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] match_cnt;
   logic          found;
   logic [PW-1:0] first_pos;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, match_cnt, found, first_pos
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, match_cnt, found, first_pos
   );
endinterface

// File: rtl/frame_scan_11011.sv
// Frame sequencer: serializes a W-bit frame MSB-first into an overlapping 11011 Moore detector.
// Define FRAME_SCAN_CARRY_EN to keep detector state across frames (default: cleared per frame).
module frame_scan_11011 #(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                rst,
   frame_scan_11011_if.slave   bus,
   output logic                busy,
   output logic                det_out
);
   localparam int CW = $clog2(W + 1);
   localparam int PW = $clog2(W);
   localparam logic [PW-1:0] LAST_IDX = PW'(W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} det_t;

   state_t        state_q, state_d;
   det_t          det_q, det_d, det_step;
   logic [W-1:0]  frame_q, frame_d;
   logic [PW-1:0] idx_q, idx_d;
   logic [CW-1:0] match_cnt_q, match_cnt_d;
   logic          found_q, found_d;
   logic [PW-1:0] first_pos_q, first_pos_d;
   logic          out_valid_q, out_valid_d;
   logic          det_out_q, det_out_d;
   logic          in_bit;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)      state_d = SHIFT;
         SHIFT:   if (idx_q == LAST_IDX) state_d = REPORT;
         REPORT:  if (bus.out_ready)     state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      bus.in_ready = (state_q == IDLE);
      busy         = (state_q != IDLE);
   end

   // The frame register shifts left, so its MSB is always the bit at the current idx.
   assign in_bit = frame_q[W-1];

   always_comb begin
      det_step = S0;
      case (det_q)
         S0:      det_step = in_bit ? S1 : S0;
         S1:      det_step = in_bit ? S2 : S0;
         S2:      det_step = in_bit ? S2 : S3;
         S3:      det_step = in_bit ? S4 : S0;
         S4:      det_step = in_bit ? S5 : S0;
         S5:      det_step = in_bit ? S2 : S3;
         default: det_step = S0;
      endcase
   end

   always_comb begin
      frame_d     = frame_q;
      idx_d       = idx_q;
      det_d       = det_q;
      match_cnt_d = match_cnt_q;
      found_d     = found_q;
      first_pos_d = first_pos_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               frame_d     = bus.in_data;
               idx_d       = '0;
               match_cnt_d = '0;
               found_d     = 1'b0;
               first_pos_d = '0;
`ifdef FRAME_SCAN_CARRY_EN
               det_d       = det_q;
`else
               det_d       = S0;
`endif
            end
         end
         SHIFT: begin
            frame_d = {frame_q[W-2:0], 1'b0};
            idx_d   = idx_q + 1'b1;
            det_d   = det_step;
            if (det_step == S5) begin
               match_cnt_d = match_cnt_q + 1'b1;
               if (!found_q) begin
                  found_d     = 1'b1;
                  first_pos_d = idx_q;
               end
            end
            if (idx_q == LAST_IDX) out_valid_d = 1'b1;
         end
         REPORT: begin
            if (bus.out_ready) out_valid_d = 1'b0;
         end
         default: ;
      endcase
      det_out_d = (det_d == S5);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q     <= '0;
         idx_q       <= '0;
         det_q       <= S0;
         match_cnt_q <= '0;
         found_q     <= 1'b0;
         first_pos_q <= '0;
         out_valid_q <= 1'b0;
         det_out_q   <= 1'b0;
      end else begin
         frame_q     <= frame_d;
         idx_q       <= idx_d;
         det_q       <= det_d;
         match_cnt_q <= match_cnt_d;
         found_q     <= found_d;
         first_pos_q <= first_pos_d;
         out_valid_q <= out_valid_d;
         det_out_q   <= det_out_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.match_cnt = match_cnt_q;
   assign bus.found     = found_q;
   assign bus.first_pos = first_pos_q;
   assign det_out       = det_out_q;
endmodule

// File: tb/tb_frame_scan_11011.sv
// Directed self-checking bench for frame_scan_11011; expected values worked out by hand per frame.
module tb_frame_scan_11011;
   localparam int W  = 16;
   localparam int CW = $clog2(W + 1);
   localparam int PW = $clog2(W);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy, det_out;
   int   n_chk  = 0;
   int   n_pass = 0;

   frame_scan_11011_if #(.W(W)) bus ();

   frame_scan_11011 #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .busy    (busy),
      .det_out (det_out)
   );

   always #5 clk = ~clk;

   // Stimulus driver: called at a negedge with out_ready low; returns edges from accept to out_valid.
   task automatic run_frame(input logic [W-1:0] data, output int lat, output int pulses, output bit ok);
      int g;
      ok = 1'b1; lat = 0; pulses = 0; g = 0;
      bus.in_data  = data;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!bus.in_ready) ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (!bus.out_valid && lat < W + 10) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (det_out) pulses++;
      end
      if (!bus.out_valid) ok = 1'b0;
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++; if (bus.in_ready !== 1'b1)  $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
      n_chk++; if (busy !== 1'b0)          $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      n_chk++; if (det_out !== 1'b0)       $display("FAIL reset_det_out got=%b exp=0", det_out); else n_pass++;
      n_chk++; if (bus.match_cnt !== '0 || bus.found !== 1'b0 || bus.first_pos !== '0)
         $display("FAIL reset_results got cnt=%0d found=%b pos=%0d exp 0/0/0", bus.match_cnt, bus.found, bus.first_pos);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      $display("reset released: in_ready=%b busy=%b", bus.in_ready, busy);
   endtask

   task automatic test_single();
      int lat, pulses; bit ok;
      run_frame(16'hD800, lat, pulses, ok);
      $display("frame D800: lat=%0d cnt=%0d found=%b pos=%0d pulses=%0d", lat, bus.match_cnt, bus.found, bus.first_pos, pulses);
      n_chk++; if (!ok)          $display("FAIL single_timeout got=timeout exp=out_valid"); else n_pass++;
      n_chk++; if (lat !== W)    $display("FAIL single_latency got=%0d exp=%0d", lat, W); else n_pass++;
      n_chk++; if (bus.match_cnt !== CW'(1)) $display("FAIL single_cnt got=%0d exp=1", bus.match_cnt); else n_pass++;
      n_chk++; if (bus.found !== 1'b1)       $display("FAIL single_found got=%b exp=1", bus.found); else n_pass++;
      n_chk++; if (bus.first_pos !== PW'(4)) $display("FAIL single_pos got=%0d exp=4", bus.first_pos); else n_pass++;
      n_chk++; if (pulses !== 1) $display("FAIL single_pulses got=%0d exp=1", pulses); else n_pass++;
      n_chk++; if (bus.in_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL single_report_state got in_ready=%b busy=%b exp 0/1", bus.in_ready, busy);
      else n_pass++;
      handshake();
      n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL single_after_hs got out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
      else n_pass++;
      n_chk++; if (bus.match_cnt !== CW'(1)) $display("FAIL single_held_cnt got=%0d exp=1", bus.match_cnt); else n_pass++;
   endtask

   task automatic test_overlap();
      int lat, pulses; bit ok;
      run_frame(16'hDB6C, lat, pulses, ok);
      $display("frame DB6C: lat=%0d cnt=%0d found=%b pos=%0d pulses=%0d", lat, bus.match_cnt, bus.found, bus.first_pos, pulses);
      n_chk++; if (!ok) $display("FAIL overlap_timeout got=timeout exp=out_valid"); else n_pass++;
      n_chk++; if (bus.match_cnt !== CW'(4)) $display("FAIL overlap_cnt got=%0d exp=4", bus.match_cnt); else n_pass++;
      n_chk++; if (bus.first_pos !== PW'(4)) $display("FAIL overlap_pos got=%0d exp=4", bus.first_pos); else n_pass++;
      n_chk++; if (bus.found !== 1'b1)       $display("FAIL overlap_found got=%b exp=1", bus.found); else n_pass++;
      n_chk++; if (pulses !== 4) $display("FAIL overlap_pulses got=%0d exp=4", pulses); else n_pass++;
      handshake();
   endtask

   task automatic test_zero_ones();
      logic [W-1:0] frames [2];
      int lat, pulses; bit ok;
      frames[0] = 16'h0000;
      frames[1] = 16'hFFFF;
      for (int k = 0; k < 2; k++) begin
         run_frame(frames[k], lat, pulses, ok);
         $display("frame %h: cnt=%0d found=%b pos=%0d", frames[k], bus.match_cnt, bus.found, bus.first_pos);
         n_chk++; if (!ok) $display("FAIL flat_timeout frame=%h got=timeout exp=out_valid", frames[k]); else n_pass++;
         n_chk++; if (bus.match_cnt !== '0 || bus.found !== 1'b0 || bus.first_pos !== '0)
            $display("FAIL flat_results frame=%h got cnt=%0d found=%b pos=%0d exp 0/0/0",
                     frames[k], bus.match_cnt, bus.found, bus.first_pos);
         else n_pass++;
         handshake();
      end
   endtask

   task automatic test_backpressure();
      int lat, pulses, g; bit ok;
      run_frame(16'hDB6C, lat, pulses, ok);
      n_chk++; if (!ok) $display("FAIL bp_timeout got=timeout exp=out_valid"); else n_pass++;
      bus.in_data  = 16'hFFFF;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         $display("bp hold %0d: out_valid=%b cnt=%0d pos=%0d in_ready=%b", c, bus.out_valid, bus.match_cnt, bus.first_pos, bus.in_ready);
         n_chk++; if (bus.out_valid !== 1'b1 || bus.match_cnt !== CW'(4) || bus.first_pos !== PW'(4) || bus.in_ready !== 1'b0)
            $display("FAIL bp_hold cycle=%0d got ov=%b cnt=%0d pos=%0d rdy=%b exp 1/4/4/0",
                     c, bus.out_valid, bus.match_cnt, bus.first_pos, bus.in_ready);
         else n_pass++;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_chk++; if (busy !== 1'b1) $display("FAIL bp_next_accept got busy=%b exp=1", busy); else n_pass++;
      g = 0;
      while (!bus.out_valid && g < W + 10) begin
         @(posedge clk);
         @(negedge clk);
         g++;
      end
      $display("frame FFFF after bp: out_valid=%b cnt=%0d found=%b", bus.out_valid, bus.match_cnt, bus.found);
      n_chk++; if (bus.out_valid !== 1'b1 || bus.match_cnt !== '0 || bus.found !== 1'b0)
         $display("FAIL bp_next_result got ov=%b cnt=%0d found=%b exp 1/0/0", bus.out_valid, bus.match_cnt, bus.found);
      else n_pass++;
      handshake();
   endtask

   task automatic test_midreset();
      int lat, pulses; bit ok, seen;
      bus.in_data  = 16'hD800;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      n_chk++; if (bus.match_cnt !== CW'(1)) $display("FAIL midrst_pre_cnt got=%0d exp=1", bus.match_cnt); else n_pass++;
      rst = 1'b0;
      #1;
      $display("mid-frame reset: ov=%b busy=%b det=%b cnt=%0d rdy=%b", bus.out_valid, busy, det_out, bus.match_cnt, bus.in_ready);
      n_chk++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || det_out !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL midrst_ctrl got ov=%b busy=%b det=%b rdy=%b exp 0/0/0/1", bus.out_valid, busy, det_out, bus.in_ready);
      else n_pass++;
      n_chk++; if (bus.match_cnt !== '0 || bus.found !== 1'b0 || bus.first_pos !== '0)
         $display("FAIL midrst_results got cnt=%0d found=%b pos=%0d exp 0/0/0", bus.match_cnt, bus.found, bus.first_pos);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < W + 4; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      n_chk++; if (seen !== 1'b0) $display("FAIL midrst_no_result got out_valid=1 exp=0"); else n_pass++;
      run_frame(16'hD800, lat, pulses, ok);
      $display("frame D800 after reset: cnt=%0d pos=%0d", bus.match_cnt, bus.first_pos);
      n_chk++; if (!ok || bus.match_cnt !== CW'(1) || bus.first_pos !== PW'(4))
         $display("FAIL midrst_recover got ok=%b cnt=%0d pos=%0d exp 1/1/4", ok, bus.match_cnt, bus.first_pos);
      else n_pass++;
      handshake();
   endtask

   task automatic test_carry();
      int lat, pulses; bit ok;
      run_frame(16'h0006, lat, pulses, ok);
      n_chk++; if (!ok || bus.match_cnt !== '0) $display("FAIL carry_first got ok=%b cnt=%0d exp 1/0", ok, bus.match_cnt); else n_pass++;
      handshake();
      run_frame(16'hC000, lat, pulses, ok);
      $display("frame C000 after 0006: cnt=%0d found=%b pos=%0d", bus.match_cnt, bus.found, bus.first_pos);
`ifdef FRAME_SCAN_CARRY_EN
      n_chk++; if (!ok || bus.match_cnt !== CW'(1) || bus.found !== 1'b1 || bus.first_pos !== PW'(1))
         $display("FAIL carry_second got cnt=%0d found=%b pos=%0d exp 1/1/1", bus.match_cnt, bus.found, bus.first_pos);
      else n_pass++;
`else
      n_chk++; if (!ok || bus.match_cnt !== '0 || bus.found !== 1'b0)
         $display("FAIL carry_second got cnt=%0d found=%b exp 0/0", bus.match_cnt, bus.found);
      else n_pass++;
`endif
      handshake();
   endtask

   task automatic test_back_to_back();
      int t_acc [2];
      int k, ov_cycles, g;
      k = 0; ov_cycles = 0;
      t_acc[0] = 0; t_acc[1] = 0;
      bus.in_data   = 16'hD800;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3 * (W + 2) && k < 2; c++) begin
         if (bus.in_ready) begin
            t_acc[k] = c;
            k++;
         end
         if (bus.out_valid) begin
            ov_cycles++;
            n_chk++; if (bus.match_cnt !== CW'(1)) $display("FAIL b2b_cnt got=%0d exp=1", bus.match_cnt); else n_pass++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      $display("back-to-back: accepts=%0d period=%0d ov_cycles=%0d", k, t_acc[1] - t_acc[0], ov_cycles);
      n_chk++; if (k !== 2 || t_acc[1] - t_acc[0] !== W + 2)
         $display("FAIL b2b_period got accepts=%0d period=%0d exp 2/%0d", k, t_acc[1] - t_acc[0], W + 2);
      else n_pass++;
      n_chk++; if (ov_cycles !== 1) $display("FAIL b2b_ov_width got=%0d exp=1", ov_cycles); else n_pass++;
      g = 0;
      while (busy && g < 2 * W) begin
         @(negedge clk);
         g++;
      end
      n_chk++; if (busy !== 1'b0) $display("FAIL b2b_drain got busy=1 exp=0"); else n_pass++;
      bus.out_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_overlap();
      test_zero_ones();
      test_backpressure();
      test_midreset();
      test_carry();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
